fc_lif_seq: RTL and testbench

Sequential fully-connected spiking layer that sits directly downstream of `conv_act_pool`. It consumes the 7×7 map of 3-bit pooled activations (`out_p`) and produces one spike bit and one 16-bit membrane value for each of 10 output neurons. It computes one MAC per cycle against an external synchronous weight ROM, so the parallel 49×10 multiplier array is never built. Membrane state persists across timesteps until cleared.

---
 rtl/snn_pkg.sv | 31 +++
 rtl/lif_fire.sv | 24 ++
 rtl/fc_lif_seq.sv | 190 +++++++++++++++++++
 tb/tb_fc_lif_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared widths, FSM encoding and saturation helper for the spiking layers.
package snn_pkg;

    localparam int unsigned N_IN  = 49;
    localparam int unsigned N_OUT = 10;
    localparam int unsigned XW    = 3;
    localparam int unsigned WW    = 16;
    localparam int unsigned ACCW  = 24;

    localparam logic signed [WW-1:0] VTH = 16'sd256;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t FIRE  = 2'd3;

    localparam logic signed [ACCW:0] SatMax = (ACCW+1)'((2 ** (WW - 1)) - 1);
    localparam logic signed [ACCW:0] SatMin = ~SatMax;

    // Clamp a membrane sum to the signed WW-bit range.
    function automatic logic signed [WW-1:0] sat16(input logic signed [ACCW:0] val);
        if (val > SatMax) begin
            return SatMax[WW-1:0];
        end else if (val < SatMin) begin
            return SatMin[WW-1:0];
        end
        return val[WW-1:0];
    endfunction

endpackage

// File: rtl/lif_fire.sv
// Combinational leaky-integrate-and-fire update: saturated add, threshold, reset-on-fire.
module lif_fire
    import snn_pkg::*;
#(
    parameter logic signed [WW-1:0] Vth = VTH
) (
    input  logic signed [WW-1:0]   v_old_i,
    input  logic signed [ACCW-1:0] acc_i,
    output logic signed [WW-1:0]   v_new_o,
    output logic                   spike_o
);

    logic signed [ACCW:0] vsum;
    logic signed [WW-1:0] vsat;

    always_comb begin
        vsum    = $signed({{(ACCW + 1 - WW){v_old_i[WW-1]}}, v_old_i})
                + $signed({acc_i[ACCW-1], acc_i});
        vsat    = sat16(vsum);
        spike_o = (vsat >= Vth);
        v_new_o = spike_o ? '0 : vsat;
    end

endmodule

// File: rtl/fc_lif_seq.sv
// Sequential fully-connected LIF layer: one MAC per cycle against an external weight ROM.
module fc_lif_seq
    import snn_pkg::*;
#(
    parameter int unsigned          N_IN  = 49,
    parameter int unsigned          N_OUT = 10,
    parameter int unsigned          XW    = 3,
    parameter int unsigned          WW    = 16,
    parameter int unsigned          ACCW  = 24,
    parameter logic signed [WW-1:0] VTH   = 16'sd256,
    parameter int unsigned          AW    = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clr_state,
    input  logic [N_IN*XW-1:0]      x_p,
    input  logic [N_OUT*WW-1:0]     b,
    output logic                    w_rd,
    output logic [AW-1:0]           w_addr,
    input  logic signed [WW-1:0]    w_data,
    output logic [N_OUT-1:0]        s_out,
    output logic [N_OUT*WW-1:0]     v_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [NW-1:0] NLast = NW'(N_OUT - 1);
    localparam logic [IW-1:0] ILast = IW'(N_IN - 1);

    state_t                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [IW-1:0]          i_q, i_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [N_IN*XW-1:0]     x_q, x_d;
    logic [N_OUT*WW-1:0]    b_q, b_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   mac_vld_q;
    logic [XW-1:0]          xi_q;
    logic signed [WW-1:0]   v_q [N_OUT];
    logic signed [WW-1:0]   v_d [N_OUT];
    logic [N_OUT-1:0]       s_q, s_d;
    logic [N_OUT-1:0]       s_out_q, s_out_d;
    logic [N_OUT*WW-1:0]    v_out_q, v_out_d;
    logic                   done_q, done_d;

    logic signed [XW+WW:0]  prod;
    logic [WW-1:0]          bias_sel;
    logic signed [WW-1:0]   v_new;
    logic                   spike;

    lif_fire #(
        .Vth(VTH)
    ) u_lif (
        .v_old_i(v_q[n_q]),
        .acc_i  (acc_q),
        .v_new_o(v_new),
        .spike_o(spike)
    );

    // Bias for the neuron about to start: live bus on start, captured copy afterwards.
    always_comb begin
        bias_sel = b[WW-1:0];
        if (state_q == FIRE && n_q != NLast) begin
            bias_sel = b_q[(int'(n_q) + 1) * WW +: WW];
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        addr_d  = addr_q;
        x_d     = x_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        v_d     = v_q;
        s_out_d = s_out_q;
        v_out_d = v_out_q;
        done_d  = 1'b0;
        prod    = $signed({1'b0, xi_q}) * w_data;

        // w_data lands one cycle after its read; mac_vld_q tracks that latency.
        if (mac_vld_q) begin
            acc_d = acc_q + ACCW'(prod);
        end

        unique case (state_q)
            IDLE: begin
                if (clr_state) begin
                    for (int k = 0; k < N_OUT; k++) begin
                        v_d[k] = '0;
                    end
                    v_out_d = '0;
                end
                if (start) begin
                    state_d = ISSUE;
                    n_d     = '0;
                    i_d     = '0;
                    addr_d  = '0;
                    x_d     = x_p;
                    b_d     = b;
                    acc_d   = {{(ACCW - WW){bias_sel[WW-1]}}, bias_sel};
                end
            end
            ISSUE: begin
                addr_d = addr_q + 1'b1;
                if (i_q == ILast) begin
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = FIRE;
            end
            FIRE: begin
                v_d[n_q] = v_new;
                s_d[n_q] = spike;
                i_d      = '0;
                if (n_q == NLast) begin
                    state_d = IDLE;
                    n_d     = '0;
                    addr_d  = '0;
                    done_d  = 1'b1;
                    s_out_d = s_d;
                    for (int k = 0; k < N_OUT; k++) begin
                        v_out_d[k*WW +: WW] = v_d[k];
                    end
                end else begin
                    state_d = ISSUE;
                    n_d     = n_q + 1'b1;
                    acc_d   = {{(ACCW - WW){bias_sel[WW-1]}}, bias_sel};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            i_q       <= '0;
            addr_q    <= '0;
            x_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mac_vld_q <= 1'b0;
            xi_q      <= '0;
            s_q       <= '0;
            s_out_q   <= '0;
            v_out_q   <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                v_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mac_vld_q <= (state_q == ISSUE);
            xi_q      <= x_q[i_q*XW +: XW];
            s_q       <= s_d;
            s_out_q   <= s_out_d;
            v_out_q   <= v_out_d;
            done_q    <= done_d;
            for (int k = 0; k < N_OUT; k++) begin
                v_q[k] <= v_d[k];
            end
        end
    end

    assign w_rd   = (state_q == ISSUE);
    assign w_addr = addr_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign s_out  = s_out_q;
    assign v_out  = v_out_q;

endmodule

// File: tb/tb_fc_lif_seq.sv
// Self-checking bench for fc_lif_seq: directed table, corner sequences and a random model run.
module tb_fc_lif_seq;

    localparam int NI = 49;
    localparam int NO = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               clr_state = 1'b0;
    logic [NI*3-1:0]    x_p = '0;
    logic [NO*16-1:0]   b = '0;
    logic               w_rd;
    logic [8:0]         w_addr;
    logic signed [15:0] w_data = '0;
    logic [NO-1:0]      s_out;
    logic [NO*16-1:0]   v_out;
    logic               busy;
    logic               done;

    logic signed [15:0] rom [NI*NO];
    int                 addr_log[$];
    int                 done_cnt = 0;
    int                 n_cmp = 0;
    int                 n_err = 0;

    int                 v_m [NO];
    logic [NO-1:0]      exp_s;
    logic [NO*16-1:0]   exp_v;

    typedef struct {
        bit                 clr;
        int                 xv;
        int                 wv;
        int                 bv;
        logic [NO-1:0]      e_s;
        logic signed [15:0] e_v;
    } vec_t;

    fc_lif_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clr_state(clr_state),
        .x_p      (x_p),
        .b        (b),
        .w_rd     (w_rd),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .s_out    (s_out),
        .v_out    (v_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd) w_data <= rom[w_addr];
    end

    always @(negedge clk) begin
        if (w_rd) addr_log.push_back(int'(w_addr));
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: per neuron, acc = bias + sum(x*w) wrapped to 24 bits, then LIF update.
    function automatic void model_step();
        int acc;
        int vs;
        for (int n = 0; n < NO; n++) begin
            acc = int'($signed(b[n*16 +: 16]));
            for (int i = 0; i < NI; i++) begin
                acc += int'(x_p[i*3 +: 3]) * int'(rom[n*NI + i]);
            end
            acc = (acc <<< 8) >>> 8;
            vs  = v_m[n] + acc;
            if (vs > 32767) vs = 32767;
            if (vs < -32768) vs = -32768;
            if (vs >= 256) begin
                exp_s[n] = 1'b1;
                v_m[n]   = 0;
            end else begin
                exp_s[n] = 1'b0;
                v_m[n]   = vs;
            end
            exp_v[n*16 +: 16] = 16'(v_m[n]);
        end
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < NO; n++) v_m[n] = 0;
    endfunction

    task automatic set_uniform(input int xv, input int wv, input int bv);
        for (int k = 0; k < NI; k++) x_p[k*3 +: 3] = 3'(xv);
        for (int k = 0; k < NI*NO; k++) rom[k] = 16'(wv);
        for (int k = 0; k < NO; k++) b[k*16 +: 16] = 16'(bv);
    endtask

    // One timestep; mid_at > 0 pulses start and clr_state at that cycle of the run.
    task automatic run_ts(input bit clr, input int mid_at, input string tag);
        int cyc;
        bit got;
        cyc = -1;
        got = 1'b0;
        start = 1'b1;
        clr_state = clr;
        tick();
        start = 1'b0;
        clr_state = 1'b0;
        if (clr) model_clear();
        model_step();
        for (int k = 0; k < NI; k++) x_p[k*3 +: 3] = 3'($urandom_range(0, 7));
        for (int k = 0; k < NO; k++) b[k*16 +: 16] = 16'($urandom);
        for (int c = 1; c <= 600; c++) begin
            start = (c == mid_at);
            clr_state = (c == mid_at);
            tick();
            if (done) begin
                cyc = c;
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        clr_state = 1'b0;
        check_int({tag, "_done_cycle"}, got ? cyc : -1, 510);
        check_vec({tag, "_s_out"}, 160'(s_out), 160'(exp_s));
        check_vec({tag, "_v_out"}, v_out, exp_v);
        check_int({tag, "_busy_after"}, int'(busy), 0);
        if (mid_at > 0) begin
            tick();
            tick();
            check_int({tag, "_no_restart"}, int'(busy), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t             tbl [7];
        int               bad;
        int               done_before;
        int               tmp;
        logic [159:0]     e;

        tbl[0] = '{1'b1, 7,  1,  0, 10'h3FF, 16'sd0};
        tbl[1] = '{1'b1, 5,  1, 10, 10'h000, 16'sd255};
        tbl[2] = '{1'b1, 5,  1, 11, 10'h3FF, 16'sd0};
        tbl[3] = '{1'b1, 1,  1,  0, 10'h000, 16'sd49};
        tbl[4] = '{1'b0, 1,  1,  0, 10'h000, 16'sd98};
        tbl[5] = '{1'b0, 1,  1,  0, 10'h000, 16'sd147};
        tbl[6] = '{1'b0, 2, -3,  0, 10'h000, -16'sd147};

        model_clear();
        exp_s = '0;
        exp_v = '0;
        set_uniform(0, 1, 0);
        tick();
        tick();
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_w_rd", int'(w_rd), 0);
        check_int("rst_w_addr", int'(w_addr), 0);
        check_vec("rst_s_out", 160'(s_out), 160'(0));
        check_vec("rst_v_out", v_out, 160'(0));
        rst = 1'b0;
        tick();

        addr_log.delete();
        run_ts(1'b0, -1, "zero");
        check_int("zero_w_rd_count", addr_log.size(), 490);
        bad = 0;
        foreach (addr_log[k]) if (addr_log[k] != k) bad++;
        check_int("zero_w_addr_order", bad, 0);

        for (int t = 0; t < 7; t++) begin
            set_uniform(tbl[t].xv, tbl[t].wv, tbl[t].bv);
            run_ts(tbl[t].clr, -1, $sformatf("tbl%0d", t));
            check_vec($sformatf("tbl%0d_s_const", t), 160'(s_out), 160'(tbl[t].e_s));
            check_vec($sformatf("tbl%0d_v_const", t), v_out, {NO{tbl[t].e_v}});
        end

        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
        model_clear();
        check_vec("clr_idle_v_out", v_out, 160'(0));
        set_uniform(1, 1, 0);
        run_ts(1'b0, -1, "after_clr");
        check_vec("after_clr_v49", v_out, {NO{16'sd49}});

        // Mid-run start and clr_state must both be ignored.
        set_uniform(1, 1, 0);
        run_ts(1'b0, 100, "mid_start");
        check_vec("mid_start_v98", v_out, {NO{16'sd98}});

        set_uniform(1, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            start = (c == 100);
            tick();
        end
        start = 1'b0;
        done_before = done_cnt;
        #2 rst = 1'b1;
        #1;
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_w_rd", int'(w_rd), 0);
        check_int("midrst_w_addr", int'(w_addr), 0);
        check_int("midrst_done", int'(done), 0);
        check_vec("midrst_s_out", 160'(s_out), 160'(0));
        check_vec("midrst_v_out", v_out, 160'(0));
        tick();
        rst = 1'b0;
        model_clear();
        tick();
        check_int("midrst_no_done", done_cnt, done_before);
        set_uniform(1, 1, 0);
        run_ts(1'b0, -1, "post_rst");
        check_vec("post_rst_v49", v_out, {NO{16'sd49}});

        set_uniform(1, 1, 0);
        b[3*16 +: 16] = -16'sd1000;
        run_ts(1'b1, -1, "neg_bias");
        check_vec("neg_bias_v3", 160'(v_out[3*16 +: 16]), 160'(16'hFC49));
        check_int("neg_bias_s3", int'(s_out[3]), 0);

        // 20 inputs at x=7 keep the extreme sums inside the 24-bit accumulator.
        for (int s = 0; s < 3; s++) begin
            set_uniform(0, 0, 0);
            for (int k = 0; k < 20; k++) x_p[k*3 +: 3] = 3'd7;
            for (int k = 0; k < NI; k++) begin
                rom[k]      = 16'sh7FFF;
                rom[NI + k] = -16'sh8000;
            end
            run_ts(s == 0, -1, $sformatf("sat%0d", s));
            e = '0;
            e[31:16] = 16'h8000;
            check_vec($sformatf("sat%0d_s_const", s), 160'(s_out), 160'(10'h001));
            check_vec($sformatf("sat%0d_v_const", s), v_out, e);
        end

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NI; k++) x_p[k*3 +: 3] = 3'($urandom_range(0, 7));
            for (int k = 0; k < NI*NO; k++) begin
                if (t < 3) tmp = int'($urandom_range(0, 400)) - 200;
                else tmp = int'($urandom_range(0, 65535)) - 32768;
                rom[k] = 16'(tmp);
            end
            for (int k = 0; k < NO; k++) begin
                tmp = int'($urandom_range(0, 4000)) - 2000;
                b[k*16 +: 16] = 16'(tmp);
            end
            run_ts($urandom_range(0, 3) == 0, -1, $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
